// File: rtl/mdu_multicycle_if.sv
// Multiply/divide unit request/response bundle between EX stage and MDU.
// Latency: n/a (wiring only).
// Backpressure: none carried here; busy tells the hazard unit to stall decode.
//
// Signals:
//   start    launch md_op this cycle
//   md_op    operation code (see mdu_multicycle)
//   rs_data  rs operand (dividend / multiplicand / MT source)
//   rt_data  rt operand (divisor / multiplier)
//   flush    cancel in-flight op and any same-cycle start
//   rd_sel   0 -> md_out=LO, 1 -> md_out=HI
//   busy     long op launching this cycle or still in flight
//   md_out   selected HI/LO value
interface mdu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             rd_sel;
  logic             busy;
  logic [WIDTH-1:0] md_out;

  modport master (
    output start, md_op, rs_data, rt_data, flush, rd_sel,
    input  busy, md_out
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, flush, rd_sel,
    output busy, md_out
  );
endinterface

// File: rtl/mdu_multicycle.sv
// Multiply/divide unit with HI/LO registers (MULT/DIV/MADD/MSUB/MTHI/MTLO).
// Latency: long ops commit HI/LO MUL_CYCLES or DIV_CYCLES edges after launch.
// Backpressure: busy is high in the launch cycle and until commit; starts while busy are dropped.
//
// Ports: clk, reset (async active-low), bus (slave side of mdu_multicycle_if:
//   start/md_op/rs_data/rt_data/flush/rd_sel in, busy/md_out out).
module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  mdu_multicycle_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MUL_L = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   hi, lo;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pend;
  logic [2*WIDTH-1:0] hilo, prod_s, prod_u, result;
  logic [WIDTH-1:0]   quot, rem;
  logic               is_mul, is_div;

  assign hilo = {hi, lo};

  assign is_mul = (bus.md_op == OP_MULT)  || (bus.md_op == OP_MULTU) ||
                  (bus.md_op == OP_MADD)  || (bus.md_op == OP_MADDU) ||
                  (bus.md_op == OP_MSUB)  || (bus.md_op == OP_MSUBU);
  assign is_div = (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);

  // Full 2*WIDTH products; operands are widened first so nothing is lost.
  assign prod_s = $signed({{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}) *
                  $signed({{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data});
  assign prod_u = {{WIDTH{1'b0}}, bus.rs_data} * {{WIDTH{1'b0}}, bus.rt_data};

  // Divide-by-zero leaves quot/rem at 0; the result mux keeps HI/LO instead.
  // MIN/-1 overflows the signed quotient, so it is pinned explicitly.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (bus.rt_data != '0) begin
      if (bus.md_op == OP_DIV) begin
        if (bus.rs_data == SMIN && bus.rt_data == '1) begin
          quot = SMIN;
          rem  = '0;
        end else begin
          quot = $signed(bus.rs_data) / $signed(bus.rt_data);
          rem  = $signed(bus.rs_data) % $signed(bus.rt_data);
        end
      end else begin
        quot = bus.rs_data / bus.rt_data;
        rem  = bus.rs_data % bus.rt_data;
      end
    end
  end

  always_comb begin
    result = hilo;
    case (bus.md_op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = hilo + prod_s;
      OP_MADDU: result = hilo + prod_u;
      OP_MSUB:  result = hilo - prod_s;
      OP_MSUBU: result = hilo - prod_u;
      OP_DIV,
      OP_DIVU:  result = (bus.rt_data == '0) ? hilo : {rem, quot};
      default:  result = hilo;
    endcase
  end

  assign bus.busy   = (bus.start && (is_mul || is_div)) || (cnt != '0);
  assign bus.md_out = bus.rd_sel ? hi : lo;

  // Flush outranks both commit and launch; a start while counting is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      pend <= '0;
    end else if (bus.flush) begin
      cnt  <= '0;
      pend <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        {hi, lo} <= pend;
        pend     <= '0;
      end
    end else if (bus.start) begin
      if (is_mul) begin
        pend <= result;
        cnt  <= MUL_L;
      end else if (is_div) begin
        pend <= result;
        cnt  <= DIV_L;
      end else if (bus.md_op == OP_MTHI) begin
        hi <= bus.rs_data;
      end else if (bus.md_op == OP_MTLO) begin
        lo <= bus.rs_data;
      end
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
// Latency: n/a.
// Backpressure: stimulus only starts when the reference model says the unit is idle.
module tb_mdu_multicycle;

  localparam int W  = 32;
  localparam int LM = 5;
  localparam int LD = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mdu_multicycle_if #(.WIDTH(W)) bus ();

  mdu_multicycle #(.WIDTH(W), .MUL_CYCLES(LM), .DIV_CYCLES(LD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_long(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? LD : LM;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
    int          sa, sb, q, r;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:  return sp;
      4'd2:  return up;
      4'd7:  return acc + sp;
      4'd8:  return acc + up;
      4'd9:  return acc - sp;
      4'd10: return acc - up;
      4'd3: begin
        if (b == 0) return acc;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      4'd4: begin
        if (b == 0) return acc;
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  bit          m_pend_vld = 1'b0;
  longint      cyc = 0, m_commit = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi       <= '0;
      m_lo       <= '0;
      m_pend_vld <= 1'b0;
      cyc        <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.flush) begin
        m_pend_vld <= 1'b0;
      end else if (m_pend_vld) begin
        if (bus.start) check("start_while_busy", {63'd0, m_pend_vld}, 64'd0);
        if (cyc + 1 == m_commit) begin
          {m_hi, m_lo} <= m_pend;
          m_pend_vld   <= 1'b0;
        end
      end else if (bus.start) begin
        if (is_long(bus.md_op)) begin
          m_pend     <= model_result(bus.md_op, bus.rs_data, bus.rt_data, {m_hi, m_lo});
          m_commit   <= cyc + 1 + latency(bus.md_op);
          m_pend_vld <= 1'b1;
        end else if (bus.md_op == 4'd5) begin
          m_hi <= bus.rs_data;
        end else if (bus.md_op == 4'd6) begin
          m_lo <= bus.rs_data;
        end
      end
    end
  end

  // Compare process: outputs are checked away from the active edge every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {63'd0, bus.busy}, {63'd0, (bus.start && is_long(bus.md_op)) || m_pend_vld});
      check("md_out", {32'd0, bus.md_out}, {32'd0, bus.rd_sel ? m_hi : m_lo});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.md_op   = 4'd0;
    bus.flush   = 1'b0;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  // Single-cycle start of a non-busy op (MTHI/MTLO).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.md_op   = op;
    bus.rs_data = a;
    bus.rt_data = b;
    step();
    idle_inputs();
  endtask

  // Launch a long op and count cycles with busy high until it drops.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy);
    int n;
    n           = 0;
    bus.start   = 1'b1;
    bus.md_op   = op;
    bus.rs_data = a;
    bus.rt_data = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      @(posedge clk);
      #2;
      idle_inputs();
    end
    idle_inputs();
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    step();
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bus.rd_sel = 1'b1;
    #1;
    check({name, "_hi"}, {32'd0, bus.md_out}, {32'd0, hi});
    bus.rd_sel = 1'b0;
    #1;
    check({name, "_lo"}, {32'd0, bus.md_out}, {32'd0, lo});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b;
    bus.rd_sel = 1'b0;
    idle_inputs();

    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    expect_hilo("reset", 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Seed HI/LO so "unchanged before commit" is visible.
    issue(4'd5, 32'h1111_1111, 32'd0);
    issue(4'd6, 32'h2222_2222, 32'd0);
    expect_hilo("mt_seed", 32'h1111_1111, 32'h2222_2222);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, LM + 1);
    expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("divu", 4'd4, 32'd100, 32'd7, LD + 1);
    expect_hilo("divu", 32'd2, 32'd14);

    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, LD + 1);
    expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, LD + 1);
    expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

    run_op("div_zero", 4'd3, 32'd1234, 32'd0, LD + 1);
    expect_hilo("div_zero", 32'd0, 32'h8000_0000);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu", 4'd8, 32'd1, 32'd1, LM + 1);
    expect_hilo("maddu", 32'd1, 32'd0);

    run_op("msub", 4'd9, 32'd1, 32'd2, LM + 1);
    expect_hilo("msub", 32'd0, 32'hFFFF_FFFE);

    // Flush three cycles after a MULT launch.
    bus.start = 1'b1; bus.md_op = 4'd1; bus.rs_data = 32'd5; bus.rt_data = 32'd5;
    step();
    idle_inputs();
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    repeat (6) step();
    expect_hilo("flush", 32'd0, 32'hFFFF_FFFE);

    // Flush and MTLO together: the write is dropped.
    bus.flush = 1'b1;
    issue(4'd6, 32'h1234_5678, 32'd0);
    expect_hilo("flush_mtlo", 32'd0, 32'hFFFF_FFFE);

    // Async reset in the middle of a DIV.
    bus.start = 1'b1; bus.md_op = 4'd3; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
    step();
    idle_inputs();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    expect_hilo("rst_mid", 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.rd_sel = 1'b0;
    issue(4'd6, 32'd5, 32'd0);
    check("mtlo_after_rst", {32'd0, bus.md_out}, 64'd5);

    // Randomized phase; starts only when the model is idle.
    for (int i = 0; i < 600; i++) begin
      bus.rd_sel = 1'($urandom);
      bus.flush  = ($urandom_range(0, 15) == 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 9);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      bus.rs_data = a;
      bus.rt_data = b;
      bus.md_op   = 4'($urandom_range(0, 15));
      bus.start   = !m_pend_vld && ($urandom_range(0, 1) == 1);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 40 && m_pend_vld; i++) step();
    check("final_idle", {63'd0, m_pend_vld}, 64'd0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
